// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit-cell length and the transmitter state encoding.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-cell counter: counts 0..CLKS_PER_BIT-1 and strobes cell_end_o on the last cycle of each cell.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic cell_end_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cell_end_o = (cnt_q == CNT_LAST);

  // next count: hold at zero while cleared, wrap at each cell end
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cell_end_o) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Byte-serial UART transmitter with one-byte holding buffer for gapless frames.
// Define UART_TX_DE_EN to add the oDE line-driver enable with a one-cell trailing guard.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] iData,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic                   iAbort,
  output logic                   TX,
  output logic                   oBusy,
  output logic                   oDone
`ifdef UART_TX_DE_EN
  ,
  output logic                   oDE
`endif
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t              state_q;
  logic [UART_DATA_W-1:0] hold_q;
  logic                   hold_full_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [2:0]             bit_idx_q;
  logic                   stop_idx_q;
  logic                   tx_q;
  logic                   done_q;
  logic                   cell_end_s;
  logic                   timer_clear_s;
  logic                   guard_run_s;
  logic                   accept_s;

`ifdef UART_TX_DE_EN
  logic de_q;
  logic guard_q;
  // the guard cell reuses the bit timer; a queued byte preempts it
  assign guard_run_s = guard_q && !hold_full_q;
  assign oDE         = de_q;
`else
  assign guard_run_s = 1'b0;
`endif

  assign oReady        = !hold_full_q && !iAbort;
  assign accept_s      = iValid && oReady;
  assign timer_clear_s = iAbort || ((state_q == TX_IDLE) && !guard_run_s);
  assign TX            = tx_q;
  assign oBusy         = (state_q != TX_IDLE);
  assign oDone         = done_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (timer_clear_s),
    .cell_end_o(cell_end_s)
  );

  // frame FSM with holding register, shifter and registered line outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= TX_IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_DE_EN
      de_q        <= 1'b0;
      guard_q     <= 1'b0;
`endif
    end else if (iAbort) begin
      state_q     <= TX_IDLE;
      hold_full_q <= 1'b0;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
`ifdef UART_TX_DE_EN
      de_q        <= 1'b0;
      guard_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept_s) begin
        hold_q      <= iData;
        hold_full_q <= 1'b1;
      end
      case (state_q)
        TX_IDLE: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= TX_START;
            tx_q        <= 1'b0;
`ifdef UART_TX_DE_EN
            de_q        <= 1'b1;
            guard_q     <= 1'b0;
          end else if (guard_q && cell_end_s) begin
            de_q        <= 1'b0;
            guard_q     <= 1'b0;
`endif
          end
        end
        TX_START: begin
          if (cell_end_s) begin
            state_q   <= TX_DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= 3'd0;
          end
        end
        TX_DATA: begin
          if (cell_end_s) begin
            shift_q <= {1'b0, shift_q[UART_DATA_W-1:1]};
            if (bit_idx_q == 3'd7) begin
              state_q    <= TX_STOP;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
              bit_idx_q  <= 3'd0;
            end else begin
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (cell_end_s) begin
            if (stop_idx_q == STOP_LAST) begin
              done_q     <= 1'b1;
              stop_idx_q <= 1'b0;
              if (hold_full_q) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= TX_START;
                tx_q        <= 1'b0;
              end else begin
                state_q <= TX_IDLE;
                tx_q    <= 1'b1;
`ifdef UART_TX_DE_EN
                guard_q <= 1'b1;
`endif
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame (default 16 clocks/bit, 1 stop bit).
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iValid = 1'b0;
  logic       iAbort = 1'b0;
  logic       oReady, TX, oBusy, oDone, oDE;

  int n_chk = 0;
  int n_fail = 0;

  // loopback receiver state
  logic       rx_en = 1'b0;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  int         rx_ferr = 0;
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_tx_frame dut (
    .clk   (clk),
    .reset (reset),
    .iData (iData),
    .iValid(iValid),
    .oReady(oReady),
    .iAbort(iAbort),
    .TX    (TX),
    .oBusy (oBusy),
    .oDone (oDone)
`ifdef UART_TX_DE_EN
    ,
    .oDE   (oDE)
`endif
  );

`ifndef UART_TX_DE_EN
  assign oDE = 1'b0;
`endif

  // expected line level at cycle c (0..159) of a frame carrying byte b
  function automatic logic exp_line(input logic [7:0] b, input int c);
    if (c < 16) return 1'b0;
    else if (c < 144) return b[(c - 16) / 16];
    else return 1'b1;
  endfunction

  // independent receiver: samples mid-cell, cycle 0 is the first low sample
  always @(negedge clk) begin
    if (!rx_en || !reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (TX === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 8 && TX !== 1'b0) rx_ferr <= rx_ferr + 1;
      if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0) rx_sh[(rx_cnt - 24) / 16] <= TX;
      if (rx_cnt == 152) begin
        if (TX !== 1'b1) rx_ferr <= rx_ferr + 1;
        rx_q.push_back(rx_sh);
        rx_busy <= 1'b0;
      end
    end
  end

  task automatic send_start(input logic [7:0] b);
    @(posedge clk); #1;
    iValid = 1'b1; iData = b;
    @(posedge clk); #1;
    iValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; iValid = 1'b0; iAbort = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (TX !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", TX); end
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    n_chk++; if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", oDone); end
    n_chk++; if (oDE !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", oDE); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", oReady); end
  endtask

  task automatic test_single_frame;
    int tx_err = 0, busy_err = 0, de_err = 0, done_cnt = 0, done_at = -1;
    logic ready0 = 1'b1;
    logic e;
    send_start(8'hA5);
    for (int t = 0; t < 180; t++) begin
      @(negedge clk);
      e = (t >= 1 && t <= 160) ? exp_line(8'hA5, t - 1) : 1'b1;
      if (TX !== e) tx_err++;
      if (oBusy !== (t >= 1 && t <= 160)) busy_err++;
`ifdef UART_TX_DE_EN
      if (oDE !== (t >= 1 && t <= 176)) de_err++;
`endif
      if (t == 0) ready0 = oReady;
      if (oDone === 1'b1) begin done_cnt++; done_at = t; end
    end
    n_chk++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL a5_ready_after_accept: got %b want 0", ready0); end
    n_chk++; if (tx_err != 0) begin n_fail++; $display("FAIL a5_waveform: %0d bad cycles, want 0", tx_err); end
    n_chk++; if (busy_err != 0) begin n_fail++; $display("FAIL a5_busy: %0d bad cycles, want 0", busy_err); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL a5_done_count: got %0d want 1", done_cnt); end
    n_chk++; if (done_at != 161) begin n_fail++; $display("FAIL a5_done_time: got %0d want 161", done_at); end
    n_chk++; if (de_err != 0) begin n_fail++; $display("FAIL a5_de: %0d bad cycles, want 0", de_err); end
  endtask

  task automatic test_back_to_back;
    int tx_err = 0, busy_err = 0, done_cnt = 0, first_done = -1, last_done = -1;
    logic e;
    @(posedge clk); #1;
    iValid = 1'b1; iData = 8'h00;
    @(posedge clk); #1;
    for (int t = 0; t < 330; t++) begin
      @(negedge clk);
      if (t >= 1 && t <= 160) e = exp_line(8'h00, t - 1);
      else if (t >= 161 && t <= 320) e = exp_line(8'hFF, t - 161);
      else e = 1'b1;
      if (TX !== e) tx_err++;
      if (oBusy !== (t >= 1 && t <= 320)) busy_err++;
      if (oDone === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = t;
        last_done = t;
      end
      if (t == 0) iData = 8'hFF;
      if (t == 2) iValid = 1'b0;
    end
    n_chk++; if (tx_err != 0) begin n_fail++; $display("FAIL b2b_waveform: %0d bad cycles, want 0", tx_err); end
    n_chk++; if (busy_err != 0) begin n_fail++; $display("FAIL b2b_no_gap: %0d bad busy cycles, want 0", busy_err); end
    n_chk++; if (done_cnt != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_chk++; if (first_done != 161) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 161", first_done); end
    n_chk++; if (last_done != 321) begin n_fail++; $display("FAIL b2b_span: got %0d want 321", last_done); end
  endtask

  task automatic test_hold_full;
    int tx_err = 0, ready_err = 0, done_cnt = 0;
    logic e;
    logic [7:0] bytes [3];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    @(posedge clk); #1;
    iValid = 1'b1; iData = 8'h11;
    @(posedge clk); #1;
    for (int t = 0; t < 490; t++) begin
      @(negedge clk);
      e = 1'b1;
      for (int k = 0; k < 3; k++)
        if (t >= 1 + 160 * k && t <= 160 + 160 * k) e = exp_line(bytes[k], t - 1 - 160 * k);
      if (TX !== e) tx_err++;
      if (t >= 2 && t <= 161 && oReady !== (t == 161)) ready_err++;
      if (oDone === 1'b1) done_cnt++;
      if (t == 0) iData = 8'h22;
      if (t == 2) iData = 8'h33;
      if (t == 162) iValid = 1'b0;
    end
    n_chk++; if (ready_err != 0) begin n_fail++; $display("FAIL hold_ready: %0d bad cycles, want 0", ready_err); end
    n_chk++; if (tx_err != 0) begin n_fail++; $display("FAIL hold_waveform: %0d bad cycles, want 0", tx_err); end
    n_chk++; if (done_cnt != 3) begin n_fail++; $display("FAIL hold_done_count: got %0d want 3", done_cnt); end
  endtask

  task automatic test_abort;
    int done_cnt = 0, idle_err = 0;
    @(posedge clk); #1;
    iValid = 1'b1; iData = 8'h53;
    @(posedge clk); #1;
    for (int t = 0; t < 272; t++) begin
      @(negedge clk);
      if (oDone === 1'b1) done_cnt++;
      if (t == 0) iData = 8'h77;
      if (t == 2) iValid = 1'b0;
      if (t == 70) begin
        n_chk++; if (TX !== 1'b0) begin n_fail++; $display("FAIL abort_pre_bit3: got %b want 0", TX); end
        iAbort = 1'b1; #1;
        n_chk++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low: got %b want 0", oReady); end
      end
      if (t == 71) begin
        n_chk++; if (TX !== 1'b1) begin n_fail++; $display("FAIL abort_tx: got %b want 1", TX); end
        n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", oBusy); end
        n_chk++; if (oDE !== 1'b0) begin n_fail++; $display("FAIL abort_de: got %b want 0", oDE); end
        iAbort = 1'b0; #1;
        n_chk++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL abort_hold_cleared: ready %b want 1", oReady); end
      end
      if (t > 71 && (TX !== 1'b1 || oBusy !== 1'b0)) idle_err++;
    end
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
    n_chk++; if (idle_err != 0) begin n_fail++; $display("FAIL abort_stays_idle: %0d bad cycles, want 0", idle_err); end
  endtask

  task automatic test_async_reset;
    int tx_err = 0, done_at = -1;
    logic e;
    send_start(8'hC3);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++; if (TX !== 1'b1) begin n_fail++; $display("FAIL areset_tx: got %b want 1", TX); end
    n_chk++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", oBusy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", oReady); end
    send_start(8'h3C);
    for (int t = 0; t < 170; t++) begin
      @(negedge clk);
      e = (t >= 1 && t <= 160) ? exp_line(8'h3C, t - 1) : 1'b1;
      if (TX !== e) tx_err++;
      if (oDone === 1'b1) done_at = t;
    end
    n_chk++; if (tx_err != 0) begin n_fail++; $display("FAIL areset_3c_waveform: %0d bad cycles, want 0", tx_err); end
    n_chk++; if (done_at != 161) begin n_fail++; $display("FAIL areset_3c_done: got %0d want 161", done_at); end
  endtask

  task automatic test_loopback;
    int idx = 0, cyc = 0, mism = 0, de_err = 0;
    rx_q.delete();
    rx_en = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b1; iData = 8'h00;
    while (idx < 256 && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      if (oReady) begin
        @(posedge clk); #1;
        idx++;
        if (idx < 256) iData = idx[7:0];
        else iValid = 1'b0;
      end
    end
    iValid = 1'b0;
    n_chk++; if (idx != 256) begin n_fail++; $display("FAIL loop_accepted: got %0d want 256", idx); end
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (oBusy === 1'b1 && cyc < 400);
    n_chk++; if (oDone !== 1'b1) begin n_fail++; $display("FAIL loop_last_done: got %b want 1", oDone); end
`ifdef UART_TX_DE_EN
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      if (oDE !== (k < 16)) de_err++;
    end
    n_chk++; if (de_err != 0) begin n_fail++; $display("FAIL loop_de_guard: %0d bad cycles, want 0", de_err); end
`endif
    cyc = 0;
    while (rx_q.size() < 256 && cyc < 2000) begin @(negedge clk); cyc++; end
    n_chk++; if (rx_q.size() != 256) begin n_fail++; $display("FAIL loop_rx_count: got %0d want 256", rx_q.size()); end
    for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== i[7:0]) mism++;
    n_chk++; if (mism != 0) begin n_fail++; $display("FAIL loop_rx_data: %0d wrong bytes, want 0", mism); end
    n_chk++; if (rx_ferr != 0) begin n_fail++; $display("FAIL loop_framing: %0d errors, want 0", rx_ferr); end
    rx_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hold_full();
    test_abort();
    test_async_reset();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
